spi_reg_bank: RTL and testbench
===============================

SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter: NUM_REGS, default 5, number of writable/readable registers (1..2**ADDR_W).
REQ-002 Parameter: DATA_W, default 8, register width in bits (>=1).
REQ-003 Parameter: ADDR_W, default 7, address field width in bits (>=1, NUM_REGS <= 2**ADDR_W).
REQ-004 Parameter: SYNC_STAGES, default 2, synchroniser depth for sclk/ncs/copi (>=2).
REQ-005 Port: clk  in  1  peripheral clock; the only clock; all state on its rising edge.
REQ-006 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port: sclk  in  1  SPI serial clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-008 Port: ncs  in  1  active-low chip select, asynchronous.
REQ-009 Port: copi  in  1  controller-out/peripheral-in data, asynchronous.
REQ-010 Port: cipo  out  1  controller-in/peripheral-out read data.
REQ-011 Port: cipo_oe  out  1  high only while a read data phase is active.
REQ-012 Port: regs_q  out  NUM_REGS*DATA_W  flattened register contents, register i at bits [i*DATA_W +: DATA_W].
REQ-013 Port: wr_pulse  out  1  one-clk pulse when a register write commits.
REQ-014 Port: wr_addr  out  ADDR_W  address of the last committed write, valid when wr_pulse high.

Function
REQ-015 sclk, ncs, copi SHALL each pass through SYNC_STAGES flops; sclk SHALL have one extra flop for edge detection.
REQ-016 Rise/fall of sclk SHALL be detected from the last two sclk sync flops; each edge yields exactly one single-clk event.
REQ-017 Frame, MSB first: 1 R/W bit (1=write, 0=read), ADDR_W address bits, DATA_W data bits; FRAME_W = 1+ADDR_W+DATA_W.
REQ-018 FSM states: IDLE, ADDR, DATA, DONE.
REQ-019 IDLE -> ADDR on synchronised ncs low; bit counter cleared, shift register cleared.
REQ-020 ADDR: copi sampled on each sclk rise; after 1+ADDR_W bits -> DATA.
REQ-021 On ADDR->DATA with read and address < NUM_REGS, the addressed register SHALL be loaded into the transmit shifter; address >= NUM_REGS loads zero.
REQ-022 DATA (read): cipo_oe=1; cipo SHALL present transmit-shifter MSB, shifter advances on each sclk fall; first data bit valid before the first data-phase sclk rise.
REQ-023 DATA (write): copi sampled on each sclk rise; after DATA_W bits -> DONE.
REQ-024 Write commit: on entry to DONE, if write and address < NUM_REGS, register updated and wr_pulse/wr_addr asserted in the same clk; latency 1 clk after the final synchronised sclk rise.
REQ-025 Address >= NUM_REGS on write: no register change, no wr_pulse.
REQ-026 DONE: further sclk edges ignored; no second commit until ncs deasserts and re-asserts.
REQ-027 Synchronised ncs high in any state SHALL return FSM to IDLE in the next clk; a partial frame SHALL never commit.
REQ-028 cipo SHALL be 0 and cipo_oe 0 in IDLE, ADDR, DONE, and during write DATA.
REQ-029 Bit counter width SHALL be clog2(FRAME_W+1); no wrap within a frame.
REQ-030 Controller sclk period SHALL be >= 2*(SYNC_STAGES+2) clk periods; faster sclk is out of contract.

Reset
REQ-031 rst_n low SHALL asynchronously force FSM=IDLE, counter=0, shifters=0, all registers=0, regs_q=0, wr_pulse=0, wr_addr=0, cipo=0, cipo_oe=0, sync flops=0 (ncs sync flops=1).
REQ-032 Reset mid-frame SHALL abandon the frame; the next frame begins only after ncs is seen high then low.

Structure
REQ-033 Shared package spi_pkg SHALL hold the FSM state enum, the R/W bit encoding constants and the default parameter values.
REQ-034 One sub-module, spi_sync_edge (parametrised synchroniser + edge detector), SHALL be instantiated for sclk/ncs/copi.

Verification
REQ-035 Defaults, write frame 1_0000010_A5 -> regs_q[23:16]=0xA5, one wr_pulse with wr_addr=2, other registers 0.
REQ-036 Write 0x3C to addr 4, then read frame 0_0000100_xx -> cipo shifts 0x3C MSB first, cipo_oe high for exactly 8 bits.
REQ-037 Write to addr 0x05 (>= NUM_REGS) -> no wr_pulse, regs_q unchanged; read addr 0x7F -> cipo returns 0x00.
REQ-038 ncs deasserted after 12 of 16 bits of a write to addr 1 -> no commit; next full frame to addr 1 with 0x11 commits 0x11.
REQ-039 rst_n pulsed low mid-frame after prior writes -> all outputs 0 immediately, following full frame commits correctly.
REQ-040 Params DATA_W=16, ADDR_W=3, NUM_REGS=8: write 0xBEEF to addr 7 then read back -> 0xBEEF, 20-bit frame, 24 extra sclk pulses ignored.

Source files
------------

// File: rtl/spi_pkg.sv
// SPI register bank shared definitions: FSM states,
// frame bit encodings and default parameter values.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DONE
   } spi_state_e;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   localparam int DEF_NUM_REGS    = 5;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_ADDR_W      = 7;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with an
// optional extra flop that yields single-clk rise/fall events.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int   STAGES  = DEF_SYNC_STAGES,
   parameter logic RST_VAL = 1'b0,
   parameter bit   EDGE    = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   localparam int DEPTH = STAGES + (EDGE ? 1 : 0);

   logic [DEPTH-1:0] sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {DEPTH{RST_VAL}};
      end else begin
         sync <= DEPTH'({sync, d});
      end
   end

   assign q = sync[STAGES-1];

   generate
      if (EDGE) begin : g_edge
         assign rise = sync[STAGES-1] & ~sync[STAGES];
         assign fall = ~sync[STAGES-1] & sync[STAGES];
      end else begin : g_no_edge
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: frames of R/W, address and data
// bits read or write a small array of registers.
module spi_reg_bank
   import spi_pkg::*;
#(
   parameter int NUM_REGS    = DEF_NUM_REGS,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclk,
   input  logic                       ncs,
   input  logic                       copi,
   output logic                       cipo,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs_q,
   output logic                       wr_pulse,
   output logic [ADDR_W-1:0]          wr_addr
);

   localparam int HDR_W   = 1 + ADDR_W;
   localparam int FRAME_W = HDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_W - 1);
   localparam logic [CNT_W-1:0] HDR_END    = CNT_W'(HDR_W);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

   logic sclk_s, sclk_rise, sclk_fall;
   logic ncs_s, ncs_rise, ncs_fall;
   logic copi_s, copi_rise, copi_fall;
   logic unused_edges;

   spi_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0),
      .EDGE    (1'b1)
   ) u_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sclk),
      .q     (sclk_s),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1),
      .EDGE    (1'b0)
   ) u_ncs (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ncs),
      .q     (ncs_s),
      .rise  (ncs_rise),
      .fall  (ncs_fall)
   );

   spi_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0),
      .EDGE    (1'b0)
   ) u_copi (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (copi),
      .q     (copi_s),
      .rise  (copi_rise),
      .fall  (copi_fall)
   );

   assign unused_edges = ^{sclk_s, ncs_rise, ncs_fall,
                           copi_rise, copi_fall};

   spi_state_e                 state, state_nxt;
   logic [CNT_W-1:0]           cnt, cnt_nxt;
   logic [HDR_W-1:0]           hdr, hdr_nxt, hdr_sh;
   logic [DATA_W-1:0]          rx, rx_nxt, rx_sh;
   logic [DATA_W-1:0]          tx, tx_nxt, rd_word;
   logic [NUM_REGS*DATA_W-1:0] regs_r;
   logic [SYNC_STAGES-1:0]     warm;
   logic                       armed, commit, wr_hit, rw;

   assign hdr_sh = HDR_W'({hdr, copi_s});
   assign rx_sh  = DATA_W'({rx, copi_s});
   assign rw     = hdr[ADDR_W];
   assign regs_q = regs_r;

   // Out-of-range addresses match nothing: reads give 0, writes drop.
   always_comb begin
      rd_word = '0;
      wr_hit  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (hdr_sh[ADDR_W-1:0] == ADDR_W'(i))
            rd_word = regs_r[i*DATA_W +: DATA_W];
         if (hdr[ADDR_W-1:0] == ADDR_W'(i))
            wr_hit = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      hdr_nxt   = hdr;
      rx_nxt    = rx;
      tx_nxt    = tx;
      commit    = 1'b0;
      cipo      = 1'b0;
      cipo_oe   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!ncs_s && armed) begin
               state_nxt = ST_ADDR;
               cnt_nxt   = '0;
               hdr_nxt   = '0;
               rx_nxt    = '0;
               tx_nxt    = '0;
            end
         end
         ST_ADDR: begin
            if (ncs_s) begin
               state_nxt = ST_IDLE;
            end else if (sclk_rise) begin
               hdr_nxt = hdr_sh;
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == HDR_LAST) begin
                  state_nxt = ST_DATA;
                  if (hdr_sh[ADDR_W] == RW_READ)
                     tx_nxt = rd_word;
               end
            end
         end
         ST_DATA: begin
            if (rw == RW_READ) begin
               cipo_oe = 1'b1;
               cipo    = tx[DATA_W-1];
            end
            if (ncs_s) begin
               state_nxt = ST_IDLE;
            end else if (sclk_rise) begin
               rx_nxt  = rx_sh;
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == FRAME_LAST) begin
                  state_nxt = ST_DONE;
                  commit    = (rw == RW_WRITE) && wr_hit;
               end
            end else if (sclk_fall && rw == RW_READ && cnt != HDR_END) begin
               // The fall right after the header keeps the MSB on the line.
               tx_nxt = tx << 1;
            end
         end
         ST_DONE: begin
            if (ncs_s)
               state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         hdr   <= '0;
         rx    <= '0;
         tx    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         hdr   <= hdr_nxt;
         rx    <= rx_nxt;
         tx    <= tx_nxt;
      end
   end

   // A frame may only start once ncs has truly been seen high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm  <= '0;
         armed <= 1'b0;
      end else begin
         warm <= SYNC_STAGES'({warm, 1'b1});
         if (warm[SYNC_STAGES-1] && ncs_s)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_r   <= '0;
         wr_pulse <= 1'b0;
         wr_addr  <= '0;
      end else begin
         wr_pulse <= commit;
         if (commit) begin
            wr_addr <= hdr[ADDR_W-1:0];
            for (int i = 0; i < NUM_REGS; i++) begin
               if (hdr[ADDR_W-1:0] == ADDR_W'(i))
                  regs_r[i*DATA_W +: DATA_W] <= rx_sh;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: default and 16-bit instances,
// write commits scoreboarded through queues, reads shifted in.
module tb_spi_reg_bank;

   localparam int HALF = 60;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic copi = 1'b0;
   logic ncs_a = 1'b1;
   logic ncs_b = 1'b1;

   logic         cipo_a, oe_a, wrp_a;
   logic [39:0]  regs_a;
   logic [6:0]   wra_a;
   logic         cipo_b, oe_b, wrp_b;
   logic [127:0] regs_b;
   logic [2:0]   wra_b;

   int vec = 0;
   int errs = 0;

   logic [39:0]  model_a = '0;
   logic [127:0] model_b = '0;
   logic [31:0]  exp_wr_a[$];
   logic [31:0]  exp_wr_b[$];
   logic [31:0]  exp_rd[$];

   always #5 clk = ~clk;

   spi_reg_bank dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk     (sclk),
      .ncs      (ncs_a),
      .copi     (copi),
      .cipo     (cipo_a),
      .cipo_oe  (oe_a),
      .regs_q   (regs_a),
      .wr_pulse (wrp_a),
      .wr_addr  (wra_a)
   );

   spi_reg_bank #(
      .NUM_REGS (8),
      .DATA_W   (16),
      .ADDR_W   (3)
   ) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk     (sclk),
      .ncs      (ncs_b),
      .copi     (copi),
      .cipo     (cipo_b),
      .cipo_oe  (oe_b),
      .regs_q   (regs_b),
      .wr_pulse (wrp_b),
      .wr_addr  (wra_b)
   );

   always @(negedge clk) begin : mon_a
      logic [31:0] e;
      if (wrp_a) begin
         vec++;
         assert (exp_wr_a.size() != 0) else begin
            errs++;
            $error("FAIL wr_a_unexpected: observed pulse addr %0h, expected none", wra_a);
         end
         if (exp_wr_a.size() != 0) begin
            e = exp_wr_a.pop_front();
            vec++;
            assert ({wra_a, regs_a[e[14:8]*8 +: 8]} === e[14:0]) else begin
               errs++;
               $error("FAIL wr_a_commit: observed %0h expected %0h",
                      {wra_a, regs_a[e[14:8]*8 +: 8]}, e[14:0]);
            end
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [31:0] e;
      if (wrp_b) begin
         vec++;
         assert (exp_wr_b.size() != 0) else begin
            errs++;
            $error("FAIL wr_b_unexpected: observed pulse addr %0h, expected none", wra_b);
         end
         if (exp_wr_b.size() != 0) begin
            e = exp_wr_b.pop_front();
            vec++;
            assert ({wra_b, regs_b[e[18:16]*16 +: 16]} === e[18:0]) else begin
               errs++;
               $error("FAIL wr_b_commit: observed %0h expected %0h",
                      {wra_b, regs_b[e[18:16]*16 +: 16]}, e[18:0]);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sck_bit(input bit sel_b, input logic v,
                          output logic c, output logic o);
      copi = v;
      #HALF;
      sclk = 1'b1;
      c = sel_b ? cipo_b : cipo_a;
      o = sel_b ? oe_b : oe_a;
      #HALF;
      sclk = 1'b0;
   endtask

   task automatic frame(input bit sel_b, input int nbits,
                        input logic [63:0] bits, input int pulses,
                        input int hdr_w, output logic [31:0] rd,
                        output int oe_cnt);
      logic c, o, v;
      rd = '0;
      oe_cnt = 0;
      if (sel_b) ncs_b = 1'b0;
      else ncs_a = 1'b0;
      for (int i = 0; i < pulses; i++) begin
         v = (i < nbits) ? bits[nbits-1-i] : 1'b0;
         sck_bit(sel_b, v, c, o);
         if (i >= hdr_w && i < nbits) rd = {rd[30:0], c};
         if (o) oe_cnt++;
      end
      #HALF;
      ncs_a = 1'b1;
      ncs_b = 1'b1;
      copi = 1'b0;
      wait_clks(12);
   endtask

   task automatic write_a(input logic [6:0] a, input logic [7:0] d);
      logic [31:0] rd;
      int oc;
      if (a < 7'd5) begin
         exp_wr_a.push_back({17'b0, a, d});
         model_a[a*8 +: 8] = d;
      end
      frame(1'b0, 16, {48'b0, 1'b1, a, d}, 16, 8, rd, oc);
      check("oe_a_write", 128'(oc), 128'(0));
   endtask

   task automatic read_a(input logic [6:0] a, input logic [7:0] e);
      logic [31:0] rd;
      int oc;
      exp_rd.push_back({24'b0, e});
      frame(1'b0, 16, {48'b0, 1'b0, a, 8'h00}, 16, 8, rd, oc);
      check("rd_a_data", 128'(rd), 128'(exp_rd.pop_front()));
      check("rd_a_oe_bits", 128'(oc), 128'(8));
   endtask

   task automatic write_b(input logic [2:0] a, input logic [15:0] d,
                          input int pulses);
      logic [31:0] rd;
      int oc;
      exp_wr_b.push_back({13'b0, a, d});
      model_b[a*16 +: 16] = d;
      frame(1'b1, 20, {44'b0, 1'b1, a, d}, pulses, 4, rd, oc);
      check("oe_b_write", 128'(oc), 128'(0));
   endtask

   task automatic read_b(input logic [2:0] a, input logic [15:0] e,
                         input int pulses);
      logic [31:0] rd;
      int oc;
      exp_rd.push_back({16'b0, e});
      frame(1'b1, 20, {44'b0, 1'b0, a, 16'h0}, pulses, 4, rd, oc);
      check("rd_b_data", 128'(rd), 128'(exp_rd.pop_front()));
      check("rd_b_oe_bits", 128'(oc), 128'(16));
   endtask

   initial begin : stim
      logic [31:0] rd;
      logic c, o;
      int oc;
      logic [15:0] hdr_bits;

      wait_clks(4);
      check("rst_regs_a", 128'(regs_a), 128'(0));
      check("rst_out_a", 128'({wrp_a, wra_a, cipo_a, oe_a}), 128'(0));
      check("rst_regs_b", regs_b, 128'(0));
      check("rst_out_b", 128'({wrp_b, wra_b, cipo_b, oe_b}), 128'(0));
      rst_n = 1'b1;
      wait_clks(6);

      write_a(7'd2, 8'hA5);
      check("w2_regs", 128'(regs_a), 128'(40'h00_00_A5_00_00));
      check("w2_q_empty", 128'(exp_wr_a.size()), 128'(0));

      write_a(7'd4, 8'h3C);
      check("w4_regs", 128'(regs_a), 128'(model_a));
      read_a(7'd4, 8'h3C);
      read_a(7'd2, 8'hA5);

      write_a(7'd5, 8'h77);
      check("w5_regs", 128'(regs_a), 128'(model_a));
      read_a(7'h7F, 8'h00);

      frame(1'b0, 16, {48'b0, 1'b1, 7'd1, 8'h99}, 12, 8, rd, oc);
      check("partial_regs", 128'(regs_a), 128'(model_a));
      write_a(7'd1, 8'h11);
      check("w1_regs", 128'(regs_a), 128'(model_a));
      read_a(7'd1, 8'h11);

      ncs_a = 1'b0;
      hdr_bits = {1'b1, 7'd3, 8'h66};
      for (int i = 0; i < 6; i++) sck_bit(1'b0, hdr_bits[15-i], c, o);
      #7;
      rst_n = 1'b0;
      #1;
      model_a = '0;
      model_b = '0;
      check("midrst_regs_a", 128'(regs_a), 128'(0));
      check("midrst_out_a", 128'({wrp_a, wra_a, cipo_a, oe_a}), 128'(0));
      check("midrst_regs_b", regs_b, 128'(0));
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(3);
      for (int i = 0; i < 16; i++) sck_bit(1'b0, hdr_bits[15-i], c, o);
      #HALF;
      ncs_a = 1'b1;
      wait_clks(12);
      check("unarmed_regs", 128'(regs_a), 128'(0));
      write_a(7'd0, 8'h5A);
      check("post_rst_regs", 128'(regs_a), 128'(40'h5A));

      write_b(3'd7, 16'hBEEF, 44);
      check("b_regs", regs_b, model_b);
      read_b(3'd7, 16'hBEEF, 44);
      write_b(3'd0, 16'h1234, 20);
      read_b(3'd0, 16'h1234, 20);
      check("b_regs2", regs_b, model_b);
      check("a_untouched", 128'(regs_a), 128'(model_a));

      wait_clks(4);
      check("q_a_drained", 128'(exp_wr_a.size()), 128'(0));
      check("q_b_drained", 128'(exp_wr_b.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
